// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Brief    : 8N1 UART receiver with 2-flop input synchroniser and
//            oversampled mid-bit sampling. The optional 8E1 mode is enabled
//            by defining UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_trigger,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int c_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_CNT_W = $clog2(c_DIV);
    localparam int c_SC_W  = $clog2(OVERSAMPLE);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
    localparam logic [c_SC_W-1:0]  c_SC_MID   = c_SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SC_W-1:0]  c_SC_LAST  = c_SC_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_SC_W-1:0]    sc_q, sc_d;
    logic [2:0]           bc_q, bc_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 armed_q, armed_d;
    logic                 trig_q, trig_d;
    logic                 ferr_q, ferr_d;
    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_stop_good;

    assign w_rx_s = sync2_q;
    assign w_tick = (cnt_q == c_CNT_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_ok_q, par_ok_d;
    assign w_stop_good = w_rx_s & par_ok_q;
`else
    assign w_stop_good = w_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            sc_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
            data_q  <= '0;
            armed_q <= 1'b0;
            trig_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            armed_q <= armed_d;
            trig_q  <= trig_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q <= par_ok_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = w_tick ? '0 : cnt_q + 1'b1;
        sc_d    = sc_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        data_d  = data_q;
        armed_d = armed_q;
        trig_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d = par_ok_q;
`endif
        case (state_q)
            IDLE: begin
                // A line stuck low must be seen high once before a new frame can start.
                if (w_rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    sc_d    = '0;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (sc_q == c_SC_MID) begin
                        if (!w_rx_s) begin
                            state_d = DATA;
                            sc_d    = '0;
                            bc_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (sc_q == c_SC_LAST) begin
                        shift_d = {w_rx_s, shift_q[7:1]};
                        sc_d    = '0;
                        if (bc_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bc_d = bc_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    if (sc_q == c_SC_LAST) begin
                        par_ok_d = ~(^shift_q ^ w_rx_s);
                        sc_d     = '0;
                        state_d  = STOP;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (sc_q == c_SC_LAST) begin
                        if (w_stop_good) begin
                            data_d = shift_q;
                            trig_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        sc_d    = '0;
                        state_d = IDLE;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data    = data_q;
    assign rx_trigger = trig_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Brief    : Directed scoreboard bench for uart_rx_frame at 16 samples/bit,
//            160 clk per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int BIT_CLK = 160;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 1683;
`else
    localparam int LAT = 1523;
`endif
    localparam int LAT_TOL = 4;

    typedef struct {
        logic       is_trig;
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_trigger;
    logic       rx_busy;
    logic       frame_err;

    exp_t       sb[$];
    logic [7:0] model_data = 8'h00;
    int         cyc        = 0;
    int         n_cmp      = 0;
    int         n_err      = 0;

    uart_rx_frame #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_trigger(rx_trigger),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; drives one frame and queues the expected strobe.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_flip, input int extra);
        exp_t e;
        e.is_trig   = stop_b & ~par_flip;
        if (e.is_trig) model_data = d;
        e.data      = model_data;
        e.start_cyc = cyc;
        sb.push_back(e);
        rx = 1'b0;
        idle_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle_clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        idle_clk(BIT_CLK);
`endif
        rx = stop_b;
        idle_clk(BIT_CLK + extra);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rx_trigger || frame_err) begin
            chk("trig_ferr_exclusive", rx_trigger & frame_err, 0);
            chk("strobe_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                int   lat;
                e   = sb.pop_front();
                lat = cyc - e.start_cyc;
                chk("strobe_kind_trig", rx_trigger, e.is_trig);
                chk("strobe_rx_data", rx_data, e.data);
                chk("strobe_latency_ok", (lat >= LAT - LAT_TOL && lat <= LAT + LAT_TOL), 1);
            end
        end
    end

    initial begin
        #20_000_000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_clk(5);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_trigger", rx_trigger, 0);
        chk("reset_rx_busy", rx_busy, 0);
        chk("reset_frame_err", frame_err, 0);
        rst = 1'b0;
        idle_clk(2 * BIT_CLK);

        send_frame(8'h72, 1'b1, 1'b0, 0);
        wait_drain("drain_single");
        idle_clk(200);
        chk("hold_72", rx_data, 8'h72);

        send_frame(8'h6C, 1'b1, 1'b0, 0);
        send_frame(8'h75, 1'b1, 1'b0, 0);
        wait_drain("drain_b2b");
        chk("hold_75", rx_data, 8'h75);
        idle_clk(BIT_CLK);

        rx = 1'b0;
        idle_clk(10);
        chk("glitch_busy_high", rx_busy, 1);
        idle_clk(30);
        rx = 1'b1;
        idle_clk(100);
        chk("glitch_busy_low", rx_busy, 0);
        chk("glitch_rx_data", rx_data, 8'h75);
        idle_clk(BIT_CLK);

        send_frame(8'h72, 1'b1, 1'b0, 0);
        send_frame(8'h30, 1'b0, 1'b0, 240);
        wait_drain("drain_ferr");
        chk("ferr_line_low_idle", rx_busy, 0);
        chk("ferr_hold_72", rx_data, 8'h72);
        rx = 1'b1;
        idle_clk(2 * BIT_CLK);
        send_frame(8'h31, 1'b1, 1'b0, 0);
        wait_drain("drain_31");
        chk("hold_31", rx_data, 8'h31);
        idle_clk(BIT_CLK);

        // 0x64 aborted by reset during data bit 4
        rx = 1'b0;
        idle_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h64 >> i) & 8'h01;
            idle_clk(BIT_CLK);
        end
        rx = 1'b0;
        idle_clk(BIT_CLK / 2);
        chk("abort_busy_before", rx_busy, 1);
        rst = 1'b1;
        idle_clk(1);
        chk("abort_rx_data", rx_data, 8'h00);
        chk("abort_rx_trigger", rx_trigger, 0);
        chk("abort_rx_busy", rx_busy, 0);
        chk("abort_frame_err", frame_err, 0);
        rst        = 1'b0;
        model_data = 8'h00;
        rx         = 1'b1;
        idle_clk(3 * BIT_CLK);
        chk("abort_no_strobe", rx_data, 8'h00);
        send_frame(8'h64, 1'b1, 1'b0, 0);
        wait_drain("drain_64");
        chk("hold_64", rx_data, 8'h64);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h30, 1'b1, 1'b0, 0);
        send_frame(8'h30, 1'b1, 1'b1, 0);
        wait_drain("drain_parity");
        chk("parity_hold_30", rx_data, 8'h30);
`endif

        idle_clk(BIT_CLK);
        chk("final_queue_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- 8N1 UART receiver. Deserialises the asynchronous serial line into bytes.
- Presents each byte on rx_data with a one-cycle rx_trigger strobe. This is exactly the interface the command-control decoder consumes.
- Sits between the board RX pin and the command decoder. Handles line synchronisation, 16x oversampling, start-bit validation and stop-bit framing checks.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Must be even and at least 8.
- Derived: DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer truncation. Must be at least 2.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  raw serial line. Idles high. Asynchronous to clk.
- rx_data  out  8  last correctly framed byte. Held until the next good frame.
- rx_trigger  out  1  one-cycle pulse. rx_data is valid in the same cycle.
- rx_busy  out  1  high while in START, DATA or STOP.
- frame_err  out  1  one-cycle pulse when the stop bit (or parity, if enabled) fails.

Behaviour:
- Interface (decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rx_data=8'h00, rx_trigger=0, rx_busy=0, frame_err=0. State=IDLE, counters=0. Synchroniser flops=1. armed=0.
- Input path: rx passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s, which adds 2 cycles of input latency.
- Tick generator:
  - Counter runs 0..DIV-1. tick=1 in the cycle the count equals DIV-1, then the counter wraps to 0.
  - The counter is cleared to 0 on the IDLE->START transition, so sampling is phase-aligned to the start edge.
- armed flag:
  - Set when rx_s=1 in IDLE.
  - Cleared on entry to START.
  - A line held low (break, or frame_err with rx stuck low) never re-triggers until rx_s has been seen high.
- FSM states are IDLE, START, DATA, STOP. Sample counter sc counts ticks. Bit counter bc runs 0..7.
  - IDLE: when armed=1 and rx_s=0, go to START with sc=0.
  - START: on each tick, sc++.
    - When sc reaches OVERSAMPLE/2-1 (mid start bit): if rx_s=0, go to DATA with sc=0, bc=0.
    - If rx_s=1 at that point, the low was a glitch: return to IDLE with no outputs.
  - DATA: on each tick, sc++. When sc reaches OVERSAMPLE-1 (mid bit):
    - Shift rx_s into the shift register MSB, shifting right (LSB first on the line).
    - Set sc=0.
    - If bc=7, go to STOP; otherwise bc++.
  - STOP: on a tick, when sc reaches OVERSAMPLE-1 (mid stop bit):
    - If rx_s=1: rx_data<=shift, rx_trigger=1 for exactly one cycle.
    - If rx_s=0: frame_err=1 for one cycle, and rx_data is unchanged.
    - Either way, go to IDLE.
- Timing: the strobe occurs at mid stop bit, about 9.5 bit times after the start edge plus 2 synchroniser cycles. Returning at mid stop bit allows back-to-back frames with no idle gap.
- rx_trigger and frame_err are never high in the same cycle.
- rx_busy = (state != IDLE).
- A synchronous rst in any state aborts the frame immediately. The next cycle shows reset values, and no strobe is generated for the aborted frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP and samples the parity bit at mid bit.
  - Even parity is required: XOR of the 8 data bits and the parity bit = 0.
  - On parity mismatch, the frame still proceeds to STOP. At the stop sample, frame_err pulses instead of rx_trigger, and rx_data is unchanged.
  - Strobe occurs about 10.5 bit times after the start edge.
- When undefined: 8N1 only. No PARITY state and no parity logic.

Test Plan:
All tests use CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, so DIV=10 and 1 bit = 160 clk.
- Single byte: after idle high, send 8'h72 -> one rx_trigger pulse about 1520+2 clk after the start edge. rx_data=8'h72 in that cycle and held after. frame_err stays 0.
- Back-to-back: 8'h6C then 8'h75 with zero idle bits -> two rx_trigger pulses about 1600 clk apart. rx_data=8'h6C, then 8'h75.
- Glitch rejection: rx low for 40 clk, then high -> rx_busy asserts then drops. No rx_trigger, no frame_err, rx_data unchanged.
- Framing error: after a good 8'h72, send 8'h30 with stop bit=0 and rx held low for 400 clk -> single frame_err pulse. rx_data stays 8'h72. No new frame starts until rx returns high. Then send 8'h31 -> rx_data=8'h31.
- Reset mid-frame: assert rst for 1 cycle during bit 4 of 8'h64 -> outputs at reset values next cycle, no strobe. A following 8'h64 is received correctly.
- With UART_RX_PARITY_EN: 8'h30 + parity 0 -> rx_trigger, rx_data=8'h30. Then 8'h30 + parity 1 -> frame_err, rx_data stays 8'h30.
